// File: rtl/imem_boot_ctrl.sv
// Instruction memory boot controller: loads little-endian words from a byte
// stream while the core is held in reset, then maps fetch onto the memory.
module imem_boot_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              core_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       PC_F,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       Instr_F,
    output logic              fetch_fault,
    output logic              load_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        HALT,
        HDR0,
        HDR1,
        DATA,
        RUN
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t            state;
    logic [7:0]        n_lo;
    logic [15:0]       n_words;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [23:0]       word_buf;
    logic              accept;
    logic              last_word;
    logic [16:0]       hdr_cnt;

    assign busy       = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign byte_ready = busy;
    assign accept     = byte_valid && byte_ready;
    assign hdr_cnt    = {1'b0, byte_data, n_lo};
    assign last_word  = 17'(word_cnt) == (17'(n_words) - 17'd1);

    assign mem_raddr   = PC_F[ADDR_W+1:2];
    assign fetch_fault = (state == RUN) &&
                         ((PC_F[1:0] != 2'b00) || (PC_F[31:ADDR_W+2] != '0));
    assign Instr_F     = ((state == RUN) && !fetch_fault) ? mem_rdata : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HALT;
            core_rst  <= 1'b1;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            load_err  <= 1'b0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            word_buf  <= '0;
            n_lo      <= '0;
            n_words   <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                HALT, RUN: begin
                    // core_rst drops one cycle after entering RUN so the
                    // final memory write lands before the core fetches
                    if (state == RUN) core_rst <= 1'b0;
                    if (load_start) begin
                        state    <= HDR0;
                        core_rst <= 1'b1;
                        load_err <= 1'b0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        n_lo  <= byte_data;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        n_words <= {byte_data, n_lo};
                        if (hdr_cnt == 17'd0) begin
                            state <= RUN;
                        end else if (hdr_cnt > MAX_WORDS) begin
                            load_err <= 1'b1;
                            state    <= HALT;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_waddr <= word_cnt[ADDR_W-1:0];
                                mem_wdata <= {byte_data, word_buf};
                                word_cnt  <= word_cnt + 1'b1;
                                if (last_word) state <= RUN;
                            end
                        endcase
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Sequences the instruction memory between a boot-load phase and a run phase.
- Boot-load phase: accepts a byte stream from an external loader (UART receiver or debug port), assembles little-endian 32-bit words and writes them into the word-addressed instruction memory. The core is held in reset throughout.
- Run phase: releases the core, maps the fetch-stage PC onto the memory read address and gates the fetched instruction.
- Sits between the fetch stage (PC_F/Instr_F) and the instruction memory array.

Parameters:
- ADDR_W, 12, word-address width; memory depth is 2**ADDR_W words (4096).
- NOP_INSTR, 32'h00000013, instruction driven to fetch when not in RUN (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse that begins a load session.
- byte_valid  in  1  loader byte strobe.
- byte_data  in  8  loader byte.
- byte_ready  out  1  controller accepts byte this cycle.
- core_rst  out  1  reset to the pipeline; high except in RUN.
- mem_we  out  1  instruction memory write enable.
- mem_waddr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- PC_F  in  32  fetch-stage PC.
- mem_raddr  out  ADDR_W  read word address; equals PC_F[ADDR_W+1:2] (combinational, all states).
- mem_rdata  in  32  combinational read data from memory.
- Instr_F  out  32  instruction to fetch stage.
- fetch_fault  out  1  RUN and (PC_F[1:0]!=0 or PC_F[31:ADDR_W+2]!=0).
- load_err  out  1  sticky error flag for the last session.
- busy  out  1  high in HDR0, HDR1, DATA.

Behaviour:

Reset:
- On rst: state=HALT, core_rst=1, byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, load_err=0, byte counter=0, word counter=0.
- Memory contents are not touched by reset.

States:
- HALT: waits for load_start.
- HDR0: takes the word-count low byte.
- HDR1: takes the word-count high byte.
- DATA: takes payload bytes.
- RUN: core executes.

Transitions:
- load_start (in any state other than HDR0, HDR1 or DATA) -> HDR0. Clears load_err and the counters; core_rst goes high the next cycle. load_start is ignored while busy.
- A byte is accepted when byte_valid && byte_ready. byte_ready=1 in HDR0, HDR1 and DATA, otherwise 0.
- HDR0: on an accepted byte, N[7:0]=byte_data -> HDR1.
- HDR1: on an accepted byte, N[15:8]=byte_data.
  - Full count {byte_data, N[7:0]} == 0 -> RUN.
  - Full count > 2**ADDR_W -> load_err=1, go to HALT.
  - Otherwise -> DATA.
- DATA: bytes are little-endian; byte k of a word goes to bits [8k+7:8k].
  - On the 4th accepted byte of a word, the next cycle has mem_we=1 for exactly one cycle, mem_waddr=word counter and mem_wdata=the assembled word. The write is registered, giving 1-cycle latency.
  - The word counter increments after each write.
  - When the write of word N-1 is issued -> RUN. core_rst deasserts in the cycle after mem_we for the last word.
- RUN: core_rst=0.
  - Instr_F=mem_rdata when fetch_fault=0, else NOP_INSTR.
  - In all non-RUN states, Instr_F=NOP_INSTR.
- Byte_valid while byte_ready=0: the byte is dropped with no side effects.
- Gaps in byte_valid are allowed anywhere, and partial words are held indefinitely.

Boundary conditions:
- N = 2**ADDR_W: legal. The last address written is 2**ADDR_W-1, and the word counter does not wrap before the transition to RUN.
- rst mid-session: back to HALT immediately. Partial memory writes remain; no further write is issued.
- load_start in RUN: re-enters HDR0 and holds the core in reset; Instr_F becomes NOP the next cycle.

Test Plan:
- Reset, then load_start and bytes 02,00, 13,05,10,00, 93,05,20,00 -> mem_we pulses with (0,32'h00100513) and (1,32'h00200593). core_rst falls 1 cycle after the second write; state is RUN.
- In RUN, PC_F=32'h4 with mem_rdata=32'h00200593 -> mem_raddr=1, Instr_F=32'h00200593. PC_F=32'h6 -> fetch_fault=1, Instr_F=32'h00000013.
- Header 01,10 (N=4097) -> load_err=1, HALT, no mem_we, core_rst=1. A following session with N=0 -> load_err cleared, RUN with no writes.
- Payload bytes separated by random idle cycles (0-5) with byte_valid pulsed outside sessions -> identical writes to the contiguous case; stray bytes have no effect.
- rst asserted after 6 of 8 payload bytes -> HALT, core_rst=1, exactly one write (word 0) occurred; a new session loads correctly.
- load_start pulsed in RUN -> core_rst=1 next cycle, busy=1, Instr_F=NOP. A load_start during DATA is ignored (counters unchanged).
